// File: rtl/elevator_step.sv
// Two-car elevator stepping stage: per car DOOR -> DECIDE -> MOVE, one floor per 2+MOVE_CYCLES cycles.
// Registered outputs, no backpressure; optional trip counters under ELEV_TRIP_COUNT_EN.

module elevator_car #(
   parameter int         MOVE_CYCLES = 4,
   parameter logic [2:0] START_FLOOR = 3'd1,
   parameter logic       START_DIR   = 1'b1
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_start,
   input  logic       i_turn,
   input  logic [6:0] i_hold,
   input  logic [5:0] i_board_dest,
   output logic [2:0] o_floor,
   output logic       o_dir,
   output logic [5:0] o_boarding,
   output logic [1:0] o_board_ack,
   output logic       o_halt
`ifdef ELEV_TRIP_COUNT_EN
   ,
   output logic [7:0] o_trips
`endif
);
   localparam int CW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(MOVE_CYCLES - 1);

   typedef enum logic [2:0] {S_IDLE, S_DOOR, S_DECIDE, S_MOVE, S_HALT} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [2:0]      r_floor;
   logic            r_dir;
   logic [5:0]      r_boarding;
   logic [1:0]      r_ack;
   logic [CW-1:0]   r_cnt;
   logic            w_in_door, w_in_decide, w_in_move, w_move_last, w_halt;
   logic [2:0]      w_slot0, w_slot1, w_floor_step;
   logic [1:0]      w_free, w_ack;
   logic            w_dir_nxt;
   logic            w_unused;

   // Alight is decided purely by slot value; the evaluator's alight flag is informational here.
   assign w_unused = i_hold[5];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (i_start) w_state_nxt = S_DOOR;
         S_DOOR:   w_state_nxt = i_hold[6] ? S_HALT : S_DECIDE;
         S_DECIDE: w_state_nxt = S_MOVE;
         S_MOVE:   if (w_move_last) w_state_nxt = S_DOOR;
         S_HALT:   w_state_nxt = S_HALT;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_in_door   = (r_state == S_DOOR);
      w_in_decide = (r_state == S_DECIDE);
      w_in_move   = (r_state == S_MOVE);
      w_halt      = (r_state == S_HALT);
      w_move_last = w_in_move && (r_cnt == CNT_LAST);
   end

   // Alight first, then passenger 0 and passenger 1 each take the lowest slot the evaluator marked free.
   always_comb begin
      w_slot0 = r_boarding[2:0];
      w_slot1 = r_boarding[5:3];
      if (w_slot0 == r_floor) w_slot0 = 3'd0;
      if (w_slot1 == r_floor) w_slot1 = 3'd0;
      w_free = i_hold[4:3];
      w_ack  = 2'b00;
      if (i_hold[2]) begin
         if (i_hold[0]) begin
            if (w_free[0]) begin
               w_slot0 = i_board_dest[2:0]; w_free[0] = 1'b0; w_ack[0] = 1'b1;
            end else if (w_free[1]) begin
               w_slot1 = i_board_dest[2:0]; w_free[1] = 1'b0; w_ack[0] = 1'b1;
            end
         end
         if (i_hold[1]) begin
            if (w_free[0]) begin
               w_slot0 = i_board_dest[5:3]; w_free[0] = 1'b0; w_ack[1] = 1'b1;
            end else if (w_free[1]) begin
               w_slot1 = i_board_dest[5:3]; w_free[1] = 1'b0; w_ack[1] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      w_dir_nxt = r_dir ^ i_turn;
      if (r_floor == 3'd1)      w_dir_nxt = 1'b1;
      else if (r_floor == 3'd7) w_dir_nxt = 1'b0;
      w_floor_step = r_floor;
      if (r_dir && (r_floor < 3'd7))       w_floor_step = r_floor + 3'd1;
      else if (!r_dir && (r_floor > 3'd1)) w_floor_step = r_floor - 3'd1;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_floor    <= START_FLOOR;
         r_dir      <= START_DIR;
         r_boarding <= 6'd0;
         r_ack      <= 2'b00;
         r_cnt      <= '0;
      end else begin
         r_ack <= 2'b00;
         if (w_in_door && !i_hold[6]) begin
            r_boarding <= {w_slot1, w_slot0};
            r_ack      <= w_ack;
         end
         if (w_in_decide) r_dir <= w_dir_nxt;
         if (w_in_move) begin
            if (w_move_last) begin
               r_cnt   <= '0;
               r_floor <= w_floor_step;
            end else begin
               r_cnt <= r_cnt + CW'(1);
            end
         end
      end
   end

`ifdef ELEV_TRIP_COUNT_EN
   logic [7:0] r_trips;
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                               r_trips <= 8'd0;
      else if (w_move_last && r_trips != 8'hFF) r_trips <= r_trips + 8'd1;
   end
   assign o_trips = r_trips;
`endif

   assign o_floor     = r_floor;
   assign o_dir       = r_dir;
   assign o_boarding  = r_boarding;
   assign o_board_ack = r_ack;
   assign o_halt      = w_halt;
endmodule

module elevator_step #(
   parameter int MOVE_CYCLES   = 4,
   parameter int START_FLOOR_1 = 1,
   parameter int START_FLOOR_2 = 7
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_start,
   input  logic [1:0] i_turn,
   input  logic [6:0] i_hold_1,
   input  logic [6:0] i_hold_2,
   input  logic [5:0] i_board_dest_1,
   input  logic [5:0] i_board_dest_2,
   output logic [2:0] o_curr_elevator_1,
   output logic [2:0] o_curr_elevator_2,
   output logic [1:0] o_dir_elevator,
   output logic [5:0] o_boarding_1,
   output logic [5:0] o_boarding_2,
   output logic [1:0] o_board_ack_1,
   output logic [1:0] o_board_ack_2,
   output logic       o_done
`ifdef ELEV_TRIP_COUNT_EN
   ,
   output logic [7:0] o_trips_1,
   output logic [7:0] o_trips_2
`endif
);
   logic w_halt_1, w_halt_2;

   elevator_car #(
      .MOVE_CYCLES (MOVE_CYCLES),
      .START_FLOOR (3'(START_FLOOR_1)),
      .START_DIR   (1'b1)
   ) u_car1 (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_start      (i_start),
      .i_turn       (i_turn[1]),
      .i_hold       (i_hold_1),
      .i_board_dest (i_board_dest_1),
      .o_floor      (o_curr_elevator_1),
      .o_dir        (o_dir_elevator[1]),
      .o_boarding   (o_boarding_1),
      .o_board_ack  (o_board_ack_1),
      .o_halt       (w_halt_1)
`ifdef ELEV_TRIP_COUNT_EN
      ,
      .o_trips      (o_trips_1)
`endif
   );

   elevator_car #(
      .MOVE_CYCLES (MOVE_CYCLES),
      .START_FLOOR (3'(START_FLOOR_2)),
      .START_DIR   (1'b0)
   ) u_car2 (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_start      (i_start),
      .i_turn       (i_turn[0]),
      .i_hold       (i_hold_2),
      .i_board_dest (i_board_dest_2),
      .o_floor      (o_curr_elevator_2),
      .o_dir        (o_dir_elevator[0]),
      .o_boarding   (o_boarding_2),
      .o_board_ack  (o_board_ack_2),
      .o_halt       (w_halt_2)
`ifdef ELEV_TRIP_COUNT_EN
      ,
      .o_trips      (o_trips_2)
`endif
   );

   assign o_done = w_halt_1 & w_halt_2;
endmodule

// File: tb/tb_elevator_step.sv
// Directed bench for elevator_step: stepping, boarding/alighting, turns, floor limits, halt and reset abort.
module tb_elevator_step;
   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [1:0] turn;
   logic [6:0] hold_1, hold_2;
   logic [5:0] dest_1, dest_2;
   logic [2:0] floor_1, floor_2;
   logic [1:0] dir;
   logic [5:0] boarding_1, boarding_2;
   logic [1:0] ack_1, ack_2;
   logic       done;
`ifdef ELEV_TRIP_COUNT_EN
   logic [7:0] trips_1, trips_2;
`endif

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   elevator_step #(.MOVE_CYCLES(4), .START_FLOOR_1(1), .START_FLOOR_2(7)) dut (
      .i_clk             (clk),
      .i_rst             (rst),
      .i_start           (start),
      .i_turn            (turn),
      .i_hold_1          (hold_1),
      .i_hold_2          (hold_2),
      .i_board_dest_1    (dest_1),
      .i_board_dest_2    (dest_2),
      .o_curr_elevator_1 (floor_1),
      .o_curr_elevator_2 (floor_2),
      .o_dir_elevator    (dir),
      .o_boarding_1      (boarding_1),
      .o_boarding_2      (boarding_2),
      .o_board_ack_1     (ack_1),
      .o_board_ack_2     (ack_2),
      .o_done            (done)
`ifdef ELEV_TRIP_COUNT_EN
      ,
      .o_trips_1         (trips_1),
      .o_trips_2         (trips_2)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_total++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; turn = 2'b00;
      hold_1 = '0; hold_2 = '0; dest_1 = '0; dest_2 = '0;
      tick(2);
      rst = 1'b0;
      tick(1);
      chk("rst_floor1", 32'(floor_1), 32'd1);
      chk("rst_floor2", 32'(floor_2), 32'd7);
      chk("rst_dir", 32'(dir), 32'b10);
      chk("rst_board", 32'({boarding_1, boarding_2}), 32'd0);
      chk("rst_ack", 32'({ack_1, ack_2}), 32'd0);
      chk("rst_done", 32'(done), 32'd0);

      start = 1'b1;
      tick(1);                               // E0
      start = 1'b0;
      tick(5);                               // E5
      chk("e5_floor1", 32'(floor_1), 32'd1);
      tick(1);                               // E6
      chk("e6_floor1", 32'(floor_1), 32'd2);
      chk("e6_floor2", 32'(floor_2), 32'd6);

      hold_1 = 7'b0_0_11_1_11; dest_1 = 6'o35;
      hold_2 = 7'b0_0_11_1_01; dest_2 = 6'o05;
      tick(1);                               // E7 DOOR
      chk("load_board1", 32'(boarding_1), 32'o35);
      chk("load_ack1", 32'(ack_1), 32'b11);
      chk("load_board2", 32'(boarding_2), 32'o05);
      chk("load_ack2", 32'(ack_2), 32'b01);
      hold_1 = '0; hold_2 = '0; dest_1 = '0; dest_2 = '0;
      tick(1);                               // E8
      chk("ack1_drop", 32'(ack_1), 32'b00);
      tick(4);                               // E12
      chk("e12_floor1", 32'(floor_1), 32'd3);
      chk("e12_floor2", 32'(floor_2), 32'd5);

      hold_1 = 7'b0_1_10_1_01; dest_1 = 6'o06;
      tick(1);                               // E13 DOOR at floor 3/5
      chk("alight_board1", 32'(boarding_1), 32'o65);
      chk("alight_ack1", 32'(ack_1), 32'b01);
      chk("alight_board2", 32'(boarding_2), 32'd0);
      chk("alight_ack2", 32'(ack_2), 32'b00);
      hold_1 = '0; dest_1 = '0;
      tick(1);                               // E14
      chk("ack1_pulse", 32'(ack_1), 32'b00);
      tick(4);                               // E18
      chk("e18_floor2", 32'(floor_2), 32'd4);
`ifdef ELEV_TRIP_COUNT_EN
      chk("trips1", 32'(trips_1), 32'd3);
`endif
      tick(1);                               // E19 DOOR
      turn = 2'b01;
      tick(1);                               // E20 DECIDE
      turn = 2'b00;
      chk("turn_dir", 32'(dir), 32'b11);
      tick(4);                               // E24
      chk("e24_floor2", 32'(floor_2), 32'd5);
      chk("e24_floor1", 32'(floor_1), 32'd5);
      tick(7);                               // E31 DOOR at floor 6
      chk("all_alight1", 32'(boarding_1), 32'd0);
      tick(5);                               // E36
      chk("top_floor1", 32'(floor_1), 32'd7);
      chk("top_floor2", 32'(floor_2), 32'd7);
      chk("top_dir_pre", 32'(dir), 32'b11);
      tick(2);                               // E38 DECIDE
      chk("top_dir_forced", 32'(dir), 32'b00);
      tick(4);                               // E42
      chk("e42_floor1", 32'(floor_1), 32'd6);
      chk("e42_floor2", 32'(floor_2), 32'd6);
      chk("pre_halt_done", 32'(done), 32'd0);

      hold_1 = 7'h40; hold_2 = 7'h40;
      tick(1);                               // E43 DOOR -> HALT
      chk("halt_done", 32'(done), 32'd1);
      hold_1 = '0; hold_2 = '0;
      tick(8);
      chk("halt_stays", 32'(done), 32'd1);
      chk("halt_floor1", 32'(floor_1), 32'd6);

      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      start = 1'b1;
      tick(1);                               // E0
      start = 1'b0;
      hold_1 = 7'b0_0_01_1_01; dest_1 = 6'o04;
      tick(1);                               // E1 DOOR
      chk("r2_board1", 32'(boarding_1), 32'o04);
      hold_1 = '0; dest_1 = '0;
      tick(2);                               // E3 mid-MOVE
      #2;
      rst = 1'b1;
      #1;
      chk("abort_floor1", 32'(floor_1), 32'd1);
      chk("abort_floor2", 32'(floor_2), 32'd7);
      chk("abort_dir", 32'(dir), 32'b10);
      chk("abort_board", 32'({boarding_1, boarding_2}), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      tick(1);
      rst = 1'b0;
      tick(6);
      chk("abort_idle_floor1", 32'(floor_1), 32'd1);
      chk("abort_idle_floor2", 32'(floor_2), 32'd7);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
